// File: rtl/spike_beat_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_beat_decoder
// Description : Turns AdEx positive/negative spike trains into beat records.
//               Each accepted positive edge is a beat. It reports the R-R
//               interval in cycles, the count of negative-path edges in that
//               interval, and an abnormal flag. Records are delivered through
//               a one-entry valid/ready output register.
// Revision    : 1.0  initial release
// ============================================================================
module spike_beat_decoder #(
  parameter int CNT_W       = 16,
  parameter int REFRACT_CYC = 200,
  parameter int NEG_THR     = 2,
  parameter int NEG_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike,
  input  logic             spike_neg,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic [CNT_W-1:0] beat_rr,
  output logic [NEG_W-1:0] beat_nneg,
  output logic             beat_abn,
  output logic             overrun,
  output logic             lost
);

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_REFRACT    = 2'd1,
    S_ARMED      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_refract_last = CNT_W'(REFRACT_CYC - 1);
  localparam logic [NEG_W-1:0] c_neg_one      = NEG_W'(1);
  localparam logic [NEG_W-1:0] c_neg_max      = {NEG_W{1'b1}};
  localparam logic [NEG_W-1:0] c_neg_thr      = NEG_W'(NEG_THR);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NEG_W-1:0] ncnt_q, ncnt_d;
  logic             spike_q, spike_d;
  logic             spike_neg_q, spike_neg_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] rr_q, rr_d;
  logic [NEG_W-1:0] nneg_q, nneg_d;
  logic             abn_q, abn_d;
  logic             overrun_q, overrun_d;
  logic             lost_q, lost_d;

  logic             w_pe;
  logic             w_ne;
  logic             w_emit;
  logic [NEG_W-1:0] w_ncnt_inc;

  // Next-state logic: edge detect, interval/negative counters, beat FSM and
  // the one-entry output register with overrun detection.
  always_comb begin
    w_pe        = spike & ~spike_q;
    w_ne        = spike_neg & ~spike_neg_q;
    w_ncnt_inc  = (ncnt_q == c_neg_max) ? ncnt_q : ncnt_q + c_neg_one;
    w_emit      = 1'b0;

    spike_d     = spike;
    spike_neg_d = spike_neg;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ncnt_d      = ncnt_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    nneg_d      = nneg_q;
    abn_d       = abn_q;
    overrun_d   = overrun_q;
    lost_d      = lost_q;

    case (state_q)
      S_WAIT_FIRST: begin
        // First beat only establishes the time reference; ne is ignored here.
        if (w_pe) begin
          cnt_d   = c_cnt_one;
          ncnt_d  = '0;
          state_d = S_REFRACT;
        end
      end
      S_REFRACT: begin
        cnt_d = cnt_q + c_cnt_one;
        if (w_ne) ncnt_d = w_ncnt_inc;
        if (cnt_q == c_refract_last) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (w_pe) begin
          // A coincident ne belongs to the interval that starts here.
          w_emit  = 1'b1;
          cnt_d   = c_cnt_one;
          ncnt_d  = {{(NEG_W-1){1'b0}}, w_ne};
          state_d = S_REFRACT;
        end else if (cnt_q == c_cnt_max) begin
          // Interval no longer representable: drop sync and start over.
          lost_d  = 1'b1;
          cnt_d   = '0;
          ncnt_d  = '0;
          state_d = S_WAIT_FIRST;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
          if (w_ne) ncnt_d = w_ncnt_inc;
        end
      end
      default: state_d = S_WAIT_FIRST;
    endcase

    if (w_emit) begin
      if (!valid_q || beat_ready) begin
        valid_d = 1'b1;
        rr_d    = cnt_q;
        nneg_d  = ncnt_q;
        abn_d   = (ncnt_q >= c_neg_thr);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && beat_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_WAIT_FIRST;
      cnt_q       <= '0;
      ncnt_q      <= '0;
      spike_q     <= 1'b0;
      spike_neg_q <= 1'b0;
      valid_q     <= 1'b0;
      rr_q        <= '0;
      nneg_q      <= '0;
      abn_q       <= 1'b0;
      overrun_q   <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ncnt_q      <= ncnt_d;
      spike_q     <= spike_d;
      spike_neg_q <= spike_neg_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      nneg_q      <= nneg_d;
      abn_q       <= abn_d;
      overrun_q   <= overrun_d;
      lost_q      <= lost_d;
    end
  end

  assign beat_valid = valid_q;
  assign beat_rr    = rr_q;
  assign beat_nneg  = nneg_q;
  assign beat_abn   = abn_q;
  assign overrun    = overrun_q;
  assign lost       = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_beat_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_beat_decoder
// Description : Scenario bench for spike_beat_decoder. Expected beat records
//               are queued as stimulus is driven and compared as they appear.
//               A second instance with CNT_W=10 covers counter saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spike_beat_decoder;

  typedef struct {
    int cyc;
    int rr;
    int nneg;
    bit abn;
  } rec_t;

  logic clk;
  logic rst;
  logic spike;
  logic spike_neg;
  logic beat_ready;

  logic        v1, abn1, ovr1, lost1;
  logic [15:0] rr1;
  logic [7:0]  nn1;
  logic        v2, abn2, ovr2, lost2;
  logic [9:0]  rr2;
  logic [7:0]  nn2;

  rec_t exp_q[$];
  int   checks;
  int   failures;

  spike_beat_decoder #(
    .CNT_W(16), .REFRACT_CYC(200), .NEG_THR(2), .NEG_W(8)
  ) dut (
    .clk(clk), .rst(rst), .spike(spike), .spike_neg(spike_neg),
    .beat_valid(v1), .beat_ready(beat_ready), .beat_rr(rr1),
    .beat_nneg(nn1), .beat_abn(abn1), .overrun(ovr1), .lost(lost1)
  );

  spike_beat_decoder #(
    .CNT_W(10), .REFRACT_CYC(200), .NEG_THR(2), .NEG_W(8)
  ) dut_small (
    .clk(clk), .rst(rst), .spike(spike), .spike_neg(spike_neg),
    .beat_valid(v2), .beat_ready(beat_ready), .beat_rr(rr2),
    .beat_nneg(nn2), .beat_abn(abn2), .overrun(ovr2), .lost(lost2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it in, observe 1 time unit later.
  task automatic cyc(input logic s, input logic sn, input logic rdy);
    spike      = s;
    spike_neg  = sn;
    beat_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    spike      = s;
    spike_neg  = s;
    beat_ready = 1'b1;
    rst        = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rec_t r;
    do_reset(1'b1);
    rst = 1'b0;
    #1;
    checks++; if (v1 !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%0b exp=0", v1); end
    checks++; if (rr1 !== 16'd0)  begin failures++; $display("FAIL reset_rr got=%0d exp=0", rr1); end
    checks++; if (nn1 !== 8'd0)   begin failures++; $display("FAIL reset_nneg got=%0d exp=0", nn1); end
    checks++; if (abn1 !== 1'b0)  begin failures++; $display("FAIL reset_abn got=%0b exp=0", abn1); end
    checks++; if (ovr1 !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%0b exp=0", ovr1); end
    checks++; if (lost1 !== 1'b0) begin failures++; $display("FAIL reset_lost got=%0b exp=0", lost1); end
    rst = 1'b1;
    // spike already high at release must count as the first beat
    for (int c = 0; c <= 305; c++) begin
      if (c == 300) exp_q.push_back('{300, 300, 0, 1'b0});
      cyc((c < 5) || (c == 300), (c < 3), 1'b1);
      if (v1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rst_edge_unexpected c=%0d got rr=%0d exp none", c, rr1);
        end else begin
          r = exp_q.pop_front();
          if (c !== r.cyc || rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
            failures++;
            $display("FAIL rst_edge_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                     c, rr1, nn1, abn1, r.cyc, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_edge_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_basic();
    rec_t r;
    do_reset(1'b0);
    for (int c = 0; c <= 620; c++) begin
      if (c == 310) exp_q.push_back('{310, 300, 0, 1'b0});
      if (c == 610) exp_q.push_back('{610, 300, 0, 1'b0});
      cyc((c == 10) || (c >= 310 && c < 315) || (c == 610), 1'b0, 1'b1);
      if (v1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL basic_unexpected c=%0d got rr=%0d exp none", c, rr1);
        end else begin
          r = exp_q.pop_front();
          if (c !== r.cyc || rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
            failures++;
            $display("FAIL basic_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                     c, rr1, nn1, abn1, r.cyc, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d left exp=0", exp_q.size()); end
    checks++; if (ovr1 !== 1'b0 || lost1 !== 1'b0) begin failures++; $display("FAIL basic_sticky got ovr=%0b lost=%0b exp 0 0", ovr1, lost1); end
  endtask

  task automatic test_refract();
    rec_t r;
    do_reset(1'b0);
    for (int c = 0; c <= 420; c++) begin
      if (c == 410) exp_q.push_back('{410, 400, 0, 1'b0});
      cyc((c == 10) || (c == 110) || (c == 410), 1'b0, 1'b1);
      if (v1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL refract_unexpected c=%0d got rr=%0d exp none", c, rr1);
        end else begin
          r = exp_q.pop_front();
          if (c !== r.cyc || rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
            failures++;
            $display("FAIL refract_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                     c, rr1, nn1, abn1, r.cyc, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL refract_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  // Exactly REFRACT_CYC apart is accepted; one cycle earlier is ignored.
  task automatic test_boundary();
    rec_t r;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b0);
      for (int c = 0; c <= 410; c++) begin
        if (pass == 0 && c == 210) exp_q.push_back('{210, 200, 0, 1'b0});
        if (pass == 1 && c == 400) exp_q.push_back('{400, 390, 0, 1'b0});
        cyc((c == 10) || (pass == 0 && c == 210) || (pass == 1 && (c == 209 || c == 400)), 1'b0, 1'b1);
        if (v1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL boundary_unexpected pass=%0d c=%0d got rr=%0d exp none", pass, c, rr1);
          end else begin
            r = exp_q.pop_front();
            if (c !== r.cyc || rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
              failures++;
              $display("FAIL boundary_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                       c, rr1, nn1, abn1, r.cyc, r.rr, r.nneg, r.abn);
            end
          end
        end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL boundary_missing pass=%0d got=%0d left exp=0", pass, exp_q.size()); end
    end
  endtask

  task automatic test_neg();
    rec_t r;
    logic sn;
    do_reset(1'b0);
    for (int c = 0; c <= 910; c++) begin
      if (c == 300) exp_q.push_back('{300, 300, 3, 1'b1});
      if (c == 600) exp_q.push_back('{600, 300, 1, 1'b0});
      if (c == 900) exp_q.push_back('{900, 300, 2, 1'b1});
      sn = (c == 50) || (c == 120) || (c == 180) || (c == 300) ||
           (c >= 700 && c < 720) || (c == 800);
      cyc((c == 0) || (c == 300) || (c == 600) || (c == 900), sn, 1'b1);
      if (v1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL neg_unexpected c=%0d got rr=%0d exp none", c, rr1);
        end else begin
          r = exp_q.pop_front();
          if (c !== r.cyc || rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
            failures++;
            $display("FAIL neg_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                     c, rr1, nn1, abn1, r.cyc, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL neg_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  // Stalled consumer: first record held, second dropped with overrun.
  task automatic test_back_to_back();
    rec_t r;
    do_reset(1'b0);
    for (int c = 0; c <= 900; c++) begin
      if (c == 300) exp_q.push_back('{300, 300, 0, 1'b0});
      if (c == 900) exp_q.push_back('{900, 300, 0, 1'b0});
      cyc((c == 0) || (c == 300) || (c == 600) || (c == 900), 1'b0, (c >= 700));
      if ((c == 599 || c == 650) && exp_q.size() != 0) begin
        checks++;
        if (v1 !== 1'b1 || rr1 !== exp_q[0].rr || nn1 !== exp_q[0].nneg || abn1 !== exp_q[0].abn) begin
          failures++;
          $display("FAIL hold_rec c=%0d got v=%0b rr=%0d nneg=%0d abn=%0b exp v=1 rr=%0d nneg=%0d abn=%0b",
                   c, v1, rr1, nn1, abn1, exp_q[0].rr, exp_q[0].nneg, exp_q[0].abn);
        end
      end
      if (c == 599) begin checks++; if (ovr1 !== 1'b0) begin failures++; $display("FAIL overrun_early got=%0b exp=0", ovr1); end end
      if (c == 600) begin checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", ovr1); end end
      if (c == 700) begin checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL valid_clear got=%0b exp=0", v1); end end
      if (v1 && (c + 1 >= 700)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected c=%0d got rr=%0d exp none", c, rr1);
        end else begin
          r = exp_q.pop_front();
          if (rr1 !== r.rr || nn1 !== r.nneg || abn1 !== r.abn) begin
            failures++;
            $display("FAIL b2b_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp rr=%0d nneg=%0d abn=%0b",
                     c, rr1, nn1, abn1, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d left exp=0", exp_q.size()); end
    // Asynchronous reset while a record is pending discards it.
    rst = 1'b0;
    #1;
    checks++; if (v1 !== 1'b0 || ovr1 !== 1'b0) begin failures++; $display("FAIL midreset got v=%0b ovr=%0b exp 0 0", v1, ovr1); end
    rst = 1'b1;
  endtask

  // Saturation on the CNT_W=10 instance.
  task automatic test_lost();
    rec_t r;
    do_reset(1'b0);
    for (int c = 0; c <= 1360; c++) begin
      if (c == 1350) exp_q.push_back('{1350, 250, 0, 1'b0});
      cyc((c == 0) || (c == 1100) || (c == 1350), 1'b0, 1'b1);
      if (c == 1022) begin checks++; if (lost2 !== 1'b0) begin failures++; $display("FAIL lost_early got=%0b exp=0", lost2); end end
      if (c == 1023) begin checks++; if (lost2 !== 1'b1) begin failures++; $display("FAIL lost_set got=%0b exp=1", lost2); end end
      if (v2) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL lost_unexpected c=%0d got rr=%0d exp none", c, rr2);
        end else begin
          r = exp_q.pop_front();
          if (c !== r.cyc || rr2 !== r.rr || nn2 !== r.nneg || abn2 !== r.abn) begin
            failures++;
            $display("FAIL lost_rec c=%0d got rr=%0d nneg=%0d abn=%0b exp c=%0d rr=%0d nneg=%0d abn=%0b",
                     c, rr2, nn2, abn2, r.cyc, r.rr, r.nneg, r.abn);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lost_missing got=%0d left exp=0", exp_q.size()); end
    checks++; if (lost2 !== 1'b1) begin failures++; $display("FAIL lost_sticky got=%0b exp=1", lost2); end
    checks++; if (lost1 !== 1'b0) begin failures++; $display("FAIL lost_wide got=%0b exp=0", lost1); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    spike      = 1'b0;
    spike_neg  = 1'b0;
    beat_ready = 1'b0;
    test_reset();
    test_basic();
    test_refract();
    test_boundary();
    test_neg();
    test_back_to_back();
    test_lost();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
